// File: rtl/spi_serf_pkg.sv
// Shared SPI constants and state type for the SPI master/serf pair.
// Frame length is defined once here so both ends of the bus agree.
package spi_serf_pkg;

  localparam int SPI_WIDTH = 16;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_serf_state_t;

endpackage

// File: rtl/spi_serf_if.sv
// Host-side handshake between a local controller and the SPI serf:
// response word loading, received-command readout and status flags.
interface spi_serf_if #(
  parameter int WIDTH = spi_serf_pkg::SPI_WIDTH
) ();

  logic [WIDTH-1:0] tx_data;
  logic             tx_ld;
  logic [WIDTH-1:0] rx_data;
  logic             cmd_rdy;
  logic             clr_rdy;
  logic             frame_err;

  modport master (
    output tx_data,
    output tx_ld,
    output clr_rdy,
    input  rx_data,
    input  cmd_rdy,
    input  frame_err
  );

  modport slave (
    input  tx_data,
    input  tx_ld,
    input  clr_rdy,
    output rx_data,
    output cmd_rdy,
    output frame_err
  );

endinterface

// File: rtl/spi_serf_sync_edge.sv
// Three-flop synchronizer for an asynchronous input: two metastability
// stages give the synced level, the third stage provides edge pulses.
module spi_serf_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_ff1;
  logic r_ff2;
  logic r_ff3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff1 <= RST_VAL;
      r_ff2 <= RST_VAL;
      r_ff3 <= RST_VAL;
    end else begin
      r_ff1 <= i_async;
      r_ff2 <= r_ff1;
      r_ff3 <= r_ff2;
    end
  end

  assign o_level = r_ff2;
  assign o_rise  = r_ff2 & ~r_ff3;
  assign o_fall  = ~r_ff2 & r_ff3;

endmodule

// File: rtl/spi_serf.sv
// SPI mode-3 responder: captures a WIDTH-bit command from MOSI while shifting
// a preloaded response out on MISO, MSB first, all in the clk domain.
module spi_serf
  import spi_serf_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         SS_n,
  input  logic         SCLK,
  input  logic         MOSI,
  output logic         MISO,
  spi_serf_if.slave    host
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  // Parking one past WIDTH keeps over-length frames distinguishable from good ones.
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  logic             w_ss_lvl;
  logic             w_ss_rise;
  logic             w_ss_fall;
  logic             w_sclk_lvl;
  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic             w_unused_sclk;

  logic             r_mosi_ff1;
  logic             r_mosi_ff2;

  spi_serf_state_t  r_state;
  logic [WIDTH-1:0] r_tx_buf;
  logic [WIDTH-1:0] r_shft_reg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_cmd_rdy;
  logic             r_frame_err;

  spi_serf_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (SS_n),
    .o_level (w_ss_lvl),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  spi_serf_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (SCLK),
    .o_level (w_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  assign w_unused_sclk = w_sclk_lvl ^ w_sclk_fall;

  // MOSI stops at the second stage so it lines up with the SCLK rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_ff1 <= 1'b1;
      r_mosi_ff2 <= 1'b1;
    end else begin
      r_mosi_ff1 <= MOSI;
      r_mosi_ff2 <= r_mosi_ff1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tx_buf    <= '0;
      r_shft_reg  <= '0;
      r_bit_cnt   <= '0;
      r_rx_data   <= '0;
      r_cmd_rdy   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (host.tx_ld) begin
        r_tx_buf <= host.tx_data;
      end
      if (host.clr_rdy) begin
        r_cmd_rdy <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_shft_reg  <= host.tx_ld ? host.tx_data : r_tx_buf;
            r_bit_cnt   <= '0;
            r_cmd_rdy   <= 1'b0;
            r_frame_err <= 1'b0;
            r_state     <= SHIFT;
          end
        end

        SHIFT: begin
          // Frame end takes priority over a coincident SCLK rise.
          if (w_ss_rise) begin
            r_state <= IDLE;
            if (r_bit_cnt == CNT_FULL) begin
              r_rx_data <= r_shft_reg;
              r_cmd_rdy <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else if (w_sclk_rise) begin
            r_shft_reg <= {r_shft_reg[WIDTH-2:0], r_mosi_ff2};
            if (r_bit_cnt != CNT_SAT) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign MISO           = w_ss_lvl ? 1'bz : r_shft_reg[WIDTH-1];
  assign host.rx_data   = r_rx_data;
  assign host.cmd_rdy   = r_cmd_rdy;
  assign host.frame_err = r_frame_err;

endmodule
